dma_bus_master: RTL and testbench

- 68000-style bus initiator that copies a block of 16-bit words from a source address to a destination address.
- Drives the DMA side of the CPU/DMA bus mux: DMA_Address, DMA_DataOut, DMA_AS_L, DMA_UDS_L, DMA_LDS_L and DMA_RW.
- Wins the bus from the CPU using the BR_L/BG_L/BGACK_L arbitration handshake, then runs read/write cycles terminated by the decoder's Dtack_L.
- The CPU programs it through a small word-wide register port and is told of completion by an interrupt.

---
 rtl/dma_bus_master.sv | 206 ++++++++++++++++++++
 tb/tb_dma_bus_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_master.sv
// rtl/dma_bus_master.sv - 68000-style DMA bus initiator copying a block of 16-bit words.
// Optional Dtack timeout is compiled in with `define DMA_TIMEOUT_EN.
module dma_bus_master #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int COUNT_W        = 16
) (
   input  logic               i_Clk,
   input  logic               i_Reset_H,
   input  logic               i_RegSelect_H,
   input  logic               i_RegWrite_H,
   input  logic [2:0]         i_RegAddr,
   input  logic [15:0]        i_RegDataIn,
   output logic [15:0]        o_RegDataOut,
   output logic [31:0]        o_DMA_Address,
   output logic [15:0]        o_DMA_DataOut,
   output logic               o_DMA_AS_L,
   output logic               o_DMA_UDS_L,
   output logic               o_DMA_LDS_L,
   output logic               o_DMA_RW,
   input  logic [15:0]        i_DataBusIn,
   input  logic               i_Dtack_L,
   input  logic               i_AS_L,
   output logic               o_BR_L,
   input  logic               i_BG_L,
   output logic               o_BGACK_L,
   output logic               o_DmaIrq_L
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DMA_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_RD_ADDR, S_RD_STB, S_RD_END,
      S_WR_ADDR, S_WR_STB, S_WR_END, S_RELEASE
   } state_t;

   state_t r_state, w_next_state;

   logic [31:0]        r_src, r_dst, r_addr;
   logic [15:0]        r_dout, r_hold;
   logic [COUNT_W-1:0] r_count;
   logic               r_irq_en, r_dst_fixed, r_done, r_err, r_fail;
   logic               r_stb_l, r_rw, r_br_l, r_bgack_l;
   logic [TMO_W-1:0]   r_tmo;

   logic w_wr, w_busy, w_ctrl_wr, w_cfg_wr, w_start, w_abort_wr, w_abort;
   logic w_in_stb, w_tmo, w_set_done, w_set_err;
   logic w_stb_l, w_rw, w_br_l, w_bgack_l;
   logic [31:0] w_src_inc, w_dst_inc;

   assign w_wr       = i_RegSelect_H & i_RegWrite_H;
   assign w_busy     = (r_state != S_IDLE);
   assign w_ctrl_wr  = w_wr && (i_RegAddr == 3'd5);
   assign w_cfg_wr   = w_wr && !w_busy;
   assign w_start    = w_ctrl_wr && i_RegDataIn[0] && !w_busy;
   assign w_abort_wr = w_ctrl_wr && i_RegDataIn[3];
   assign w_abort    = r_fail | w_abort_wr;
   assign w_src_inc  = r_src + 32'd2;
   assign w_dst_inc  = r_dst + 32'd2;

   assign w_in_stb = (r_state == S_RD_STB) || (r_state == S_WR_STB);
   assign w_tmo    = TMO_EN && w_in_stb && i_Dtack_L &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

   assign w_set_done = (w_start && (r_count == '0)) || ((r_state == S_RELEASE) && !r_fail);
   assign w_set_err  = (r_state == S_RELEASE) && r_fail;

   always_ff @(posedge i_Clk) begin
      if (i_Reset_H) r_state <= S_IDLE;
      else           r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_start && (r_count != '0)) w_next_state = S_REQ;
         // The CPU may still own a cycle after granting; wait for it to finish.
         S_REQ: begin
            if (w_abort_wr)                           w_next_state = S_IDLE;
            else if (!i_BG_L && i_AS_L && i_Dtack_L)  w_next_state = S_RD_ADDR;
         end
         S_RD_ADDR: w_next_state = w_abort ? S_RELEASE : S_RD_STB;
         S_RD_STB: begin
            if (!i_Dtack_L) w_next_state = S_RD_END;
            else if (w_tmo) w_next_state = S_RELEASE;
         end
         S_RD_END:  w_next_state = w_abort ? S_RELEASE : S_WR_ADDR;
         S_WR_ADDR: w_next_state = w_abort ? S_RELEASE : S_WR_STB;
         S_WR_STB: begin
            if (!i_Dtack_L) w_next_state = S_WR_END;
            else if (w_tmo) w_next_state = S_RELEASE;
         end
         S_WR_END:  w_next_state = (w_abort || (r_count == COUNT_W'(1))) ? S_RELEASE : S_RD_ADDR;
         S_RELEASE: w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase

      w_stb_l   = !((w_next_state == S_RD_STB) || (w_next_state == S_WR_STB));
      w_rw      = !((w_next_state == S_WR_ADDR) || (w_next_state == S_WR_STB));
      w_br_l    = (w_next_state != S_REQ);
      w_bgack_l = !((w_next_state == S_RD_ADDR) || (w_next_state == S_RD_STB) ||
                    (w_next_state == S_RD_END)  || (w_next_state == S_WR_ADDR) ||
                    (w_next_state == S_WR_STB)  || (w_next_state == S_WR_END));
   end

   // Bus controls are registered from the next state so they never glitch.
   always_ff @(posedge i_Clk) begin
      if (i_Reset_H) begin
         r_stb_l   <= 1'b1;
         r_rw      <= 1'b1;
         r_br_l    <= 1'b1;
         r_bgack_l <= 1'b1;
         r_addr    <= '0;
         r_dout    <= '0;
         r_hold    <= '0;
         r_tmo     <= '0;
      end else begin
         r_stb_l   <= w_stb_l;
         r_rw      <= w_rw;
         r_br_l    <= w_br_l;
         r_bgack_l <= w_bgack_l;
         if (w_next_state == S_RD_ADDR)
            r_addr <= (r_state == S_WR_END) ? w_src_inc : r_src;
         if (w_next_state == S_WR_ADDR) begin
            r_addr <= r_dst;
            r_dout <= r_hold;
         end
         if ((r_state == S_RD_STB) && !i_Dtack_L)
            r_hold <= i_DataBusIn;
         if (TMO_EN && w_in_stb && (w_next_state == r_state))
            r_tmo <= r_tmo + 1'b1;
         else
            r_tmo <= '0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset_H) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_count     <= '0;
         r_irq_en    <= 1'b0;
         r_dst_fixed <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         if (w_cfg_wr) begin
            case (i_RegAddr)
               3'd0:    r_src[31:16] <= i_RegDataIn;
               3'd1:    r_src[15:0]  <= {i_RegDataIn[15:1], 1'b0};
               3'd2:    r_dst[31:16] <= i_RegDataIn;
               3'd3:    r_dst[15:0]  <= {i_RegDataIn[15:1], 1'b0};
               3'd4:    r_count      <= COUNT_W'(i_RegDataIn);
               default: ;
            endcase
         end
         if (r_state == S_WR_END) begin
            r_src   <= w_src_inc;
            if (!r_dst_fixed) r_dst <= w_dst_inc;
            r_count <= r_count - COUNT_W'(1);
         end
         if (w_ctrl_wr) begin
            r_irq_en    <= i_RegDataIn[1];
            r_dst_fixed <= i_RegDataIn[2];
         end
         // Write-1-to-clear takes priority over a simultaneous internal set.
         if (w_ctrl_wr && i_RegDataIn[9]) r_done <= 1'b0;
         else if (w_set_done)              r_done <= 1'b1;
         if (w_ctrl_wr && i_RegDataIn[10]) r_err <= 1'b0;
         else if (w_set_err)                r_err <= 1'b1;
         if ((r_state == S_IDLE) || (r_state == S_RELEASE))
            r_fail <= 1'b0;
         else if ((w_abort_wr && (r_state != S_REQ)) || w_tmo)
            r_fail <= 1'b1;
      end
   end

   always_comb begin
      o_RegDataOut = '0;
      case (i_RegAddr)
         3'd0:    o_RegDataOut = r_src[31:16];
         3'd1:    o_RegDataOut = r_src[15:0];
         3'd2:    o_RegDataOut = r_dst[31:16];
         3'd3:    o_RegDataOut = r_dst[15:0];
         3'd4:    o_RegDataOut = 16'(r_count);
         3'd5:    o_RegDataOut = {5'b0, r_err, r_done, w_busy, 5'b0, r_dst_fixed, r_irq_en, 1'b0};
         default: o_RegDataOut = '0;
      endcase
   end

   assign o_DMA_Address = r_addr;
   assign o_DMA_DataOut = r_dout;
   assign o_DMA_AS_L    = r_stb_l;
   assign o_DMA_UDS_L   = r_stb_l;
   assign o_DMA_LDS_L   = r_stb_l;
   assign o_DMA_RW      = r_rw;
   assign o_BR_L        = r_br_l;
   assign o_BGACK_L     = r_bgack_l;
   assign o_DmaIrq_L    = ~(r_irq_en & (r_done | r_err));

endmodule

// File: tb/tb_dma_bus_master.sv
// tb/tb_dma_bus_master.sv - scoreboard bench for dma_bus_master with a bus slave and arbiter model.
`timescale 1ns/1ps
module tb_dma_bus_master;

   logic        Clk;
   logic        Reset_H, RegSelect_H, RegWrite_H;
   logic [2:0]  RegAddr;
   logic [15:0] RegDataIn, RegDataOut;
   logic [31:0] DMA_Address;
   logic [15:0] DMA_DataOut, DataBusIn;
   logic        DMA_AS_L, DMA_UDS_L, DMA_LDS_L, DMA_RW;
   logic        Dtack_L, AS_L, BR_L, BG_L, BGACK_L, DmaIrq_L;

   int n_checks = 0;
   int n_errors = 0;
   int grant_delay = 4;
   int wait_states = 1;
   bit dtack_en = 1;
   int rd_starts = 0;
   logic [31:0] exp_rd[$];
   logic [31:0] exp_wa[$];
   logic [15:0] exp_wd[$];

   dma_bus_master #(.TIMEOUT_CYCLES(8), .COUNT_W(16)) u_dut (
      .i_Clk(Clk), .i_Reset_H(Reset_H), .i_RegSelect_H(RegSelect_H),
      .i_RegWrite_H(RegWrite_H), .i_RegAddr(RegAddr), .i_RegDataIn(RegDataIn),
      .o_RegDataOut(RegDataOut), .o_DMA_Address(DMA_Address), .o_DMA_DataOut(DMA_DataOut),
      .o_DMA_AS_L(DMA_AS_L), .o_DMA_UDS_L(DMA_UDS_L), .o_DMA_LDS_L(DMA_LDS_L),
      .o_DMA_RW(DMA_RW), .i_DataBusIn(DataBusIn), .i_Dtack_L(Dtack_L), .i_AS_L(AS_L),
      .o_BR_L(BR_L), .i_BG_L(BG_L), .o_BGACK_L(BGACK_L), .o_DmaIrq_L(DmaIrq_L)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_data(input logic [31:0] a);
      return a[15:0] ^ a[31:16] ^ 16'h5A3C;
   endfunction

   task automatic push_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input int n, input bit fixed);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(src + 32'(2 * i));
         exp_wa.push_back(fixed ? dst : dst + 32'(2 * i));
         exp_wd.push_back(mem_data(src + 32'(2 * i)));
      end
   endtask

   // Bus slave: acknowledges after wait_states and checks each cycle against the scoreboard.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(negedge Clk);
         if (Reset_H || DMA_AS_L) begin
            Dtack_L = 1'b1;
            wcnt = 0;
         end else begin
            wcnt++;
            if (wcnt == 1 && DMA_RW) rd_starts++;
            if (dtack_en && wcnt > wait_states && Dtack_L) begin
               if (DMA_RW) begin
                  DataBusIn = mem_data(DMA_Address);
                  if (exp_rd.size() == 0) check_eq("sb_rd_extra", exp_rd.size(), 1);
                  else check_eq("rd_addr", DMA_Address, exp_rd.pop_front());
               end else begin
                  if (exp_wa.size() == 0) check_eq("sb_wr_extra", exp_wa.size(), 1);
                  else begin
                     check_eq("wr_addr", DMA_Address, exp_wa.pop_front());
                     check_eq("wr_data", DMA_DataOut, exp_wd.pop_front());
                  end
               end
               Dtack_L = 1'b0;
            end
         end
         if (!AS_L) check_eq("cpu_overlap", DMA_AS_L, 1);
      end
   end

   initial begin
      int gcnt;
      gcnt = 0;
      forever begin
         @(negedge Clk);
         if (BR_L) begin
            BG_L = 1'b1;
            gcnt = 0;
         end else begin
            gcnt++;
            if (gcnt >= grant_delay) BG_L = 1'b0;
         end
      end
   end

   task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge Clk);
      RegSelect_H = 1'b1; RegWrite_H = 1'b1; RegAddr = a; RegDataIn = d;
      @(negedge Clk);
      RegSelect_H = 1'b0; RegWrite_H = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      RegAddr = a;
      #1;
      check_eq(tag, RegDataOut, exp);
   endtask

   task automatic setup(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt);
      reg_write(3'd0, src[31:16]);
      reg_write(3'd1, src[15:0]);
      reg_write(3'd2, dst[31:16]);
      reg_write(3'd3, dst[15:0]);
      reg_write(3'd4, cnt);
   endtask

   task automatic wait_fin(input string tag);
      bit ok;
      ok = 0;
      RegAddr = 3'd5;
      for (int i = 0; i < 2000; i++) begin
         @(negedge Clk);
         #1;
         if (RegDataOut[10:9] != 2'b00) begin
            ok = 1;
            break;
         end
      end
      check_eq(tag, ok, 1);
      @(negedge Clk);
   endtask

   task automatic check_sb_empty(input string tag);
      check_eq({tag, "_rd_left"}, exp_rd.size(), 0);
      check_eq({tag, "_wr_left"}, exp_wa.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1);
   end

   initial begin
      Reset_H = 1; RegSelect_H = 0; RegWrite_H = 0; RegAddr = 0; RegDataIn = 0;
      DataBusIn = 0; Dtack_L = 1; AS_L = 1; BG_L = 1;
      repeat (3) @(negedge Clk);
      Reset_H = 0;
      #1;
      check_eq("rst_as",   DMA_AS_L, 1);
      check_eq("rst_uds",  DMA_UDS_L, 1);
      check_eq("rst_lds",  DMA_LDS_L, 1);
      check_eq("rst_rw",   DMA_RW, 1);
      check_eq("rst_br",   BR_L, 1);
      check_eq("rst_bgack", BGACK_L, 1);
      check_eq("rst_irq",  DmaIrq_L, 1);
      check_eq("rst_addr", DMA_Address, 0);
      check_eq("rst_dout", DMA_DataOut, 0);
      for (int r = 0; r < 8; r++) check_reg("rst_reg", 3'(r), 16'h0000);

      // Block copy with grant delay and one wait state.
      grant_delay = 4; wait_states = 1;
      setup(32'h00F0_0000, 32'hFFFF_0000, 16'd3);
      push_xfer(32'h00F0_0000, 32'hFFFF_0000, 3, 0);
      reg_write(3'd5, 16'h0003);
      wait_fin("t1_fin");
      check_reg("t1_count", 3'd4, 16'h0000);
      check_reg("t1_status", 3'd5, 16'h0202);
      check_reg("t1_src_lo", 3'd1, 16'h0006);
      check_reg("t1_dst_lo", 3'd3, 16'h0006);
      check_eq("t1_irq", DmaIrq_L, 0);
      check_eq("t1_bgack", BGACK_L, 1);
      check_sb_empty("t1");
      reg_write(3'd5, 16'h0600);
      check_eq("t1_irq_clr", DmaIrq_L, 1);

      // Fixed destination, source carries across the low half.
      grant_delay = 1; wait_states = 0;
      setup(32'h0001_FFFD, 32'h0040_0000, 16'd2);
      check_reg("t2_src_lo_b0", 3'd1, 16'hFFFC);
      push_xfer(32'h0001_FFFC, 32'h0040_0000, 2, 1);
      reg_write(3'd5, 16'h0005);
      wait_fin("t2_fin");
      check_reg("t2_src_hi", 3'd0, 16'h0002);
      check_reg("t2_src_lo", 3'd1, 16'h0000);
      check_reg("t2_dst_lo", 3'd3, 16'h0000);
      check_reg("t2_status", 3'd5, 16'h0204);
      check_eq("t2_irq", DmaIrq_L, 1);
      check_sb_empty("t2");
      reg_write(3'd5, 16'h0600);

      // START with zero count completes immediately without bus request.
      check_reg("t3_pre", 3'd5, 16'h0000);
      reg_write(3'd5, 16'h0001);
      check_reg("t3_done", 3'd5, 16'h0200);
      check_eq("t3_br", BR_L, 1);
      repeat (3) @(negedge Clk);
      check_eq("t3_br_later", BR_L, 1);
      reg_write(3'd5, 16'h0600);

      // Grant arrives while the CPU still drives AS_L low.
      AS_L = 1'b0;
      setup(32'h0000_0100, 32'h0000_0200, 16'd1);
      push_xfer(32'h0000_0100, 32'h0000_0200, 1, 0);
      reg_write(3'd5, 16'h0001);
      check_eq("t4_br", BR_L, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         #1;
         check_eq("t4_bgack_hold", BGACK_L, 1);
      end
      reg_write(3'd4, 16'd7);
      check_reg("t4_count_locked", 3'd4, 16'd1);
      AS_L = 1'b1;
      wait_fin("t4_fin");
      check_reg("t4_count", 3'd4, 16'd0);
      check_eq("t4_bgack", BGACK_L, 1);
      check_sb_empty("t4");
      reg_write(3'd5, 16'h0600);

      // ABORT during the second read of five.
      wait_states = 3;
      setup(32'h00F0_0100, 32'h00F0_0200, 16'd5);
      push_xfer(32'h00F0_0100, 32'h00F0_0200, 1, 0);
      exp_rd.push_back(32'h00F0_0102);
      rd_starts = 0;
      reg_write(3'd5, 16'h0003);
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            #2;
            if (rd_starts >= 2) begin
               seen = 1;
               break;
            end
         end
         check_eq("t5_rd2_seen", seen, 1);
      end
      reg_write(3'd5, 16'h000A);
      wait_fin("t5_fin");
      check_reg("t5_status", 3'd5, 16'h0402);
      check_reg("t5_count", 3'd4, 16'd4);
      check_eq("t5_bgack", BGACK_L, 1);
      check_eq("t5_br", BR_L, 1);
      check_eq("t5_irq", DmaIrq_L, 0);
      check_sb_empty("t5");
      reg_write(3'd5, 16'h0600);

`ifdef DMA_TIMEOUT_EN
      // Dtack never arrives; the strobe must give up after 8 cycles.
      dtack_en = 0;
      wait_states = 1;
      setup(32'h0000_1000, 32'h0000_2000, 16'd1);
      reg_write(3'd5, 16'h0001);
      begin
         bit seen;
         int n;
         seen = 0;
         n = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            #1;
            if (!DMA_AS_L) begin
               seen = 1;
               break;
            end
         end
         check_eq("t6_stb_seen", seen, 1);
         while (seen && n < 50) begin
            @(negedge Clk);
            #1;
            n++;
            if (DMA_AS_L) break;
         end
         check_eq("t6_tmo_cycles", n, 8);
      end
      wait_fin("t6_fin");
      check_reg("t6_status", 3'd5, 16'h0400);
      check_eq("t6_bgack", BGACK_L, 1);
      dtack_en = 1;
      reg_write(3'd5, 16'h0600);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
